// File: rtl/wb_rd_dma_if.sv
// Wishbone classic bus bundle shared by the read DMA master and its slave.
interface wshb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_ms,
    input  dat_sm, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_ms,
    output dat_sm, ack
  );
endinterface

// File: rtl/wb_rd_dma.sv
// Wishbone classic read DMA: fetches len words from base_adr into a stream FIFO.
// Optional ack timeout is enabled by defining WB_RD_DMA_TIMEOUT_EN.
module wb_rd_dma #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  wshb_if.master      wb_m,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, READ, PAUSE, DONE} state_t;

  state_t        state;
  logic          cyc;
  logic          stb;
  logic [3:0]    sel;
  logic [31:0]   adr;
  logic [15:0]   idx;
  logic [15:0]   len_q;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;
  logic          last;
  logic          tmo_hit;

  // An ack only counts while strobing in READ; stray acks elsewhere are ignored.
  assign push       = (state == READ) && stb && wb_m.ack;
  assign pop        = m_valid && m_ready;
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign last       = (idx == len_q - 16'd1);

  assign wb_m.cyc    = cyc;
  assign wb_m.stb    = stb;
  assign wb_m.we     = 1'b0;
  assign wb_m.sel    = sel;
  assign wb_m.adr    = adr;
  assign wb_m.dat_ms = 32'h0;

`ifdef WB_RD_DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == READ) && !wb_m.ack && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Each word gets a fresh budget: the count restarts on entering READ and on every ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state != READ || wb_m.ack) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + TW'(1);
      if (state == IDLE && start) err <= 1'b0;
      else if (tmo_hit)           err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // NOTE: state and registered bus outputs use non-blocking assignments so every
  // branch below sees the pre-edge values, avoiding ordering races between blocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cyc   <= 1'b0;
      stb   <= 1'b0;
      sel   <= 4'h0;
      adr   <= 32'h0;
      idx   <= 16'h0;
      len_q <= 16'h0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            len_q <= len;
            idx   <= 16'h0;
            adr   <= {base_adr[31:2], 2'b00};
            if (len == 16'h0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
              cyc   <= 1'b1;
              stb   <= 1'b1;
              sel   <= 4'hF;
            end
          end
        end
        READ: begin
          if (push) begin
            adr <= adr + 32'd4;
            idx <= idx + 16'd1;
            if (last) begin
              state <= DONE;
              cyc   <= 1'b0;
              stb   <= 1'b0;
              sel   <= 4'h0;
              done  <= 1'b1;
            end else if (count_next == DEPTH_C) begin
              // Drop stb so the slave is never asked for a word we cannot store.
              state <= PAUSE;
              stb   <= 1'b0;
            end
          end else if (tmo_hit) begin
            state <= DONE;
            cyc   <= 1'b0;
            stb   <= 1'b0;
            sel   <= 4'h0;
            done  <= 1'b1;
          end
        end
        PAUSE: begin
          if (count < DEPTH_C) begin
            state <= READ;
            stb   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the pointers and
  // count alone, and m_data is gated to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wb_m.dat_sm;
  end

  assign m_valid = (count != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_wb_rd_dma.sv
// Directed bench for wb_rd_dma: vector table plus len=0, reset-abort and timeout sequences.
module tb_wb_rd_dma;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] len;
  logic        busy, done, err;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;

  wshb_if wb();

  wb_rd_dma #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n), .wb_m(wb.master), .start(start),
    .base_adr(base_adr), .len(len), .busy(busy), .done(done), .err(err),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // Slave model: registered ack one cycle after a request; dat_sm follows the address.
  logic slave_en;
  always @(posedge clk) begin
    if (!rst_n) begin
      wb.ack <= 1'b0;
      wb.dat_sm <= 32'h0;
    end else if (slave_en && wb.cyc && wb.stb && !wb.ack) begin
      wb.ack <= 1'b1;
      wb.dat_sm <= word_of(wb.adr);
    end else begin
      wb.ack <= 1'b0;
    end
  end

  // Observers: accepted bus words, stream words, pulse and occupancy counters.
  logic        clr;
  logic [31:0] acked[$];
  logic [31:0] got[$];
  int done_cnt, cyc_cnt, stb_cnt, occ, max_occ;
  always @(posedge clk) begin : mon
    int occ_n;
    if (clr) begin
      acked.delete();
      got.delete();
      done_cnt <= 0; cyc_cnt <= 0; stb_cnt <= 0; occ <= 0; max_occ <= 0;
    end else if (rst_n) begin
      occ_n = occ;
      if (wb.cyc && wb.stb && wb.ack) begin
        acked.push_back(wb.adr);
        occ_n++;
      end
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        occ_n--;
      end
      occ <= occ_n;
      if (occ_n > max_occ) max_occ <= occ_n;
      if (done)   done_cnt <= done_cnt + 1;
      if (wb.cyc) cyc_cnt  <= cyc_cnt + 1;
      if (wb.stb) stb_cnt  <= stb_cnt + 1;
    end
  end

  task automatic clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    int          ready_delay;
    int          spur_at;
    int          exp_ready_acks;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int id, input vec_t v);
    int acks_at_ready = 0;
    logic stb_at_ready = 1'b1;
    bit fin = 1'b0;
    int bad_adr = 0;
    int bad_dat = 0;
    logic [31:0] a0;
    string tag;
    tag = $sformatf("v%0d", id);
    clear();
    m_ready  = (v.ready_delay == 0);
    base_adr = v.base;
    len      = v.len;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 3000 && !fin; c++) begin
      if (c == v.spur_at) begin
        base_adr = 32'h0000_0900; len = 16'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (c == v.ready_delay) begin
        acks_at_ready = acked.size();
        stb_at_ready  = wb.stb;
        m_ready       = 1'b1;
      end
      @(negedge clk);
      if (done_cnt > 0 && got.size() >= int'(v.len) && !busy) fin = 1'b1;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_finished"}, 32'(fin), 32'd1);
    check({tag, "_ack_count"}, acked.size(), 32'(v.len));
    if (acked.size() > 0) begin
      check({tag, "_first_adr"}, acked[0], v.exp_first);
      check({tag, "_last_adr"}, acked[acked.size()-1], v.exp_last);
    end
    check({tag, "_word_count"}, got.size(), 32'(v.len));
    a0 = {v.base[31:2], 2'b00};
    for (int k = 0; k < acked.size(); k++)
      if (acked[k] !== a0 + 32'(4 * k)) bad_adr++;
    for (int k = 0; k < got.size(); k++)
      if (got[k] !== word_of(a0 + 32'(4 * k))) bad_dat++;
    check({tag, "_adr_seq_errors"}, bad_adr, 0);
    check({tag, "_data_seq_errors"}, bad_dat, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_fifo_overfill"}, 32'(max_occ > DEPTH), 0);
    if (v.exp_ready_acks >= 0) begin
      check({tag, "_acks_before_drain"}, acks_at_ready, v.exp_ready_acks);
      check({tag, "_stb_in_pause"}, stb_at_ready, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 16'd4,  0, 3, -1, 32'h0000_0100, 32'h0000_010C};
    vecs[1] = '{32'hFFFF_FFF8, 16'd3,  0, 0, -1, 32'hFFFF_FFF8, 32'h0000_0000};
    vecs[2] = '{32'h0000_1003, 16'd5,  0, 0, -1, 32'h0000_1000, 32'h0000_1010};
    vecs[3] = '{32'h0000_0200, 16'd10, 50, 0, 4, 32'h0000_0200, 32'h0000_0224};
    vecs[4] = '{32'h0000_0040, 16'd1,  3, 0, -1, 32'h0000_0040, 32'h0000_0040};

    rst_n = 1'b0; start = 1'b0; base_adr = 32'h0; len = 16'h0;
    m_ready = 1'b0; slave_en = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_cyc", wb.cyc, 1'b0);
    check("rst_stb", wb.stb, 1'b0);
    check("rst_we", wb.we, 1'b0);
    check("rst_sel", wb.sel, 4'h0);
    check("rst_adr", wb.adr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // len == 0: done one cycle after start, busy for exactly that cycle, no bus cycle.
    clear();
    m_ready = 1'b1; len = 16'd0; base_adr = 32'h0000_0400; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", done, 1'b1);
    check("len0_busy", busy, 1'b1);
    @(negedge clk);
    check("len0_done_gone", done, 1'b0);
    check("len0_busy_gone", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("len0_cyc_cycles", cyc_cnt, 0);
    check("len0_done_pulses", done_cnt, 1);

    // Reset during word 2 of an 8-word transfer with the consumer stalled.
    clear();
    m_ready = 1'b0; len = 16'd8; base_adr = 32'h0000_0500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit reached = 1'b0;
      for (int c = 0; c < 100 && !reached; c++) begin
        if (acked.size() >= 2) reached = 1'b1;
        else @(negedge clk);
      end
      check("abort_reached_word2", 32'(reached), 32'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_cyc", wb.cyc, 1'b0);
    check("abort_stb", wb.stb, 1'b0);
    check("abort_m_valid", m_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    clear();
    m_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done_after", done_cnt, 0);
    check("abort_no_words", got.size(), 0);
    check("abort_bus_idle", cyc_cnt, 0);

`ifdef WB_RD_DMA_TIMEOUT_EN
    // Silent slave: cyc drops after 255 strobe cycles with err and a done pulse.
    clear();
    slave_en = 1'b0; m_ready = 1'b1; len = 16'd2; base_adr = 32'h0000_0600; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 600 && done_cnt == 0; c++) @(negedge clk);
    check("tmo_stb_cycles", stb_cnt, 255);
    check("tmo_done_pulses", done_cnt, 1);
    check("tmo_err", err, 1'b1);
    repeat (2) @(negedge clk);
    check("tmo_cyc_low", wb.cyc, 1'b0);
    check("tmo_err_sticky", err, 1'b1);
    slave_en = 1'b1; len = 16'd1; base_adr = 32'h0000_0700; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("tmo_err_cleared", err, 1'b0);
    repeat (10) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
